// File: rtl/lsu_mc.sv
// ============================================================================
// Module      : lsu_mc
// Description : Multi-cycle load/store unit with an aligned, byte-strobed
//               memory bus, load extension and misalign/fault exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mc #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 64,
    parameter int ADROFF_WIDTH = 12,
    parameter int RD_WIDTH     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_base_i,
    input  logic [ADROFF_WIDTH-1:0] req_off_i,
    input  logic [DATA_WIDTH-1:0]   req_st_dat_i,
    input  logic [1:0]              req_wdth_i,
    input  logic                    req_ls_i,
    input  logic                    req_signed_i,
    input  logic [RD_WIDTH-1:0]     req_rd_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic                    mem_rsp_valid_i,
    input  logic                    mem_rsp_err_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    wb_valid_o,
    output logic [RD_WIDTH-1:0]     wb_rd_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    st_done_o,
    output logic                    exc_valid_o,
    output logic [2:0]              exc_cause_o,
    output logic [ADDR_WIDTH-1:0]   exc_addr_o,
    output logic                    busy_o
);

    localparam int STRB      = DATA_WIDTH / 8;
    localparam int L         = $clog2(STRB);
    localparam bit DWORD_OK  = (DATA_WIDTH == 64);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_EXC  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] ea_q;
    logic [L-1:0]          lane_q;
    logic [1:0]            wdth_q;
    logic                  is_st_q;
    logic                  signed_q;
    logic [RD_WIDTH-1:0]   rd_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [STRB-1:0]       mem_wstrb_q;
    logic [DATA_WIDTH-1:0] wb_dat_q;
    logic [RD_WIDTH-1:0]   wb_rd_q;
    logic [ADDR_WIDTH-1:0] exc_addr_q;
    logic [2:0]            exc_cause_q;

    // Request-side decode
    logic [ADDR_WIDTH-1:0] w_ea;
    logic [L-1:0]          w_lane;
    logic [STRB-1:0]       w_mask;
    logic                  w_misal;
    logic                  w_illegal;
    logic                  w_accept;

    assign w_ea      = req_base_i + {{(ADDR_WIDTH-ADROFF_WIDTH){req_off_i[ADROFF_WIDTH-1]}}, req_off_i};
    assign w_lane    = w_ea[L-1:0];
    assign w_illegal = (req_wdth_i == 2'd3) && !DWORD_OK;
    assign w_accept  = req_valid_i && (state_q == S_IDLE);

    always_comb begin
        w_mask  = STRB'(8'h01);
        w_misal = 1'b0;
        case (req_wdth_i)
            2'd0: begin w_mask = STRB'(8'h01); w_misal = 1'b0;          end
            2'd1: begin w_mask = STRB'(8'h03); w_misal = w_ea[0];       end
            2'd2: begin w_mask = STRB'(8'h0F); w_misal = |w_ea[1:0];    end
            default: begin w_mask = STRB'(8'hFF); w_misal = |w_ea[2:0]; end
        endcase
    end

    // Response-side extraction and extension
    logic [DATA_WIDTH-1:0] w_sh;
    logic [DATA_WIDTH-1:0] w_keep;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [6:0]            w_nbits;
    logic                  w_sb;

    assign w_sh    = mem_rdata_i >> {lane_q, 3'b000};
    assign w_nbits = 7'd8 << wdth_q;
    assign w_keep  = ~({DATA_WIDTH{1'b1}} << w_nbits);

    always_comb begin
        w_sb = 1'b0;
        case (wdth_q)
            2'd0:    w_sb = w_sh[7];
            2'd1:    w_sb = w_sh[15];
            2'd2:    w_sb = w_sh[31];
            default: w_sb = 1'b0;
        endcase
    end

    // A dword fills the bus, so its keep mask is all ones and sign is moot
    assign w_ext = (signed_q && w_sb) ? (w_sh | ~w_keep) : (w_sh & w_keep);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = (w_illegal || w_misal) ? S_EXC : S_REQ;
                end
            end
            S_REQ:   if (mem_req_ready_i) state_d = S_WAIT;
            S_WAIT:  if (mem_rsp_valid_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ea_q        <= '0;
            lane_q      <= '0;
            wdth_q      <= '0;
            is_st_q     <= 1'b0;
            signed_q    <= 1'b0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wb_dat_q    <= '0;
            wb_rd_q     <= '0;
            exc_addr_q  <= '0;
            exc_cause_q <= '0;
        end else begin
            if (w_accept) begin
                ea_q     <= w_ea;
                lane_q   <= w_lane;
                wdth_q   <= req_wdth_i;
                is_st_q  <= req_ls_i;
                signed_q <= req_signed_i;
                rd_q     <= req_rd_i;
                if (w_illegal || w_misal) begin
                    exc_addr_q  <= w_ea;
                    exc_cause_q <= w_illegal ? 3'd4 : (req_ls_i ? 3'd1 : 3'd0);
                end else begin
                    mem_addr_q  <= {w_ea[ADDR_WIDTH-1:L], {L{1'b0}}};
                    mem_we_q    <= req_ls_i;
                    mem_wdata_q <= req_st_dat_i << {w_lane, 3'b000};
                    mem_wstrb_q <= req_ls_i ? (w_mask << w_lane) : {STRB{1'b1}};
                end
            end
            // Responses are only honoured in WAIT; stray ones elsewhere are dropped
            if ((state_q == S_WAIT) && mem_rsp_valid_i) begin
                err_q <= mem_rsp_err_i;
                if (mem_rsp_err_i) begin
                    exc_addr_q  <= ea_q;
                    exc_cause_q <= is_st_q ? 3'd3 : 3'd2;
                end else if (!is_st_q) begin
                    wb_dat_q <= w_ext;
                    wb_rd_q  <= rd_q;
                end
            end
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_addr_o      = mem_addr_q;
    assign mem_we_o        = mem_we_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_wstrb_o     = mem_wstrb_q;
    assign wb_valid_o      = (state_q == S_DONE) && !err_q && !is_st_q;
    assign st_done_o       = (state_q == S_DONE) && !err_q && is_st_q;
    assign exc_valid_o     = (state_q == S_EXC) || ((state_q == S_DONE) && err_q);
    assign wb_dat_o        = wb_dat_q;
    assign wb_rd_o         = wb_rd_q;
    assign exc_addr_o      = exc_addr_q;
    assign exc_cause_o     = exc_cause_q;

endmodule

`default_nettype wire
